// File: rtl/timer_apb_pkg.sv
// Shared definitions for the timer APB initiator: FSM encoding, bus widths
// and the timer register map.
package timer_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] TCMP0_OFF = 12'h00C;
  localparam logic [11:0] TCMP1_OFF = 12'h010;
  localparam logic [11:0] TIER_OFF  = 12'h014;
  localparam logic [11:0] TISR_OFF  = 12'h018;
  localparam logic [11:0] THCSR_OFF = 12'h01C;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter; expire flags the last allowed
// wait cycle so the FSM leaves ACCESS after exactly TIMEOUT_CYC cycles.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (en && cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);
  end

  assign expire = en && (cnt >= CNT_LAST);

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB requester: command handshake in, SETUP/ACCESS
// sequencing with bounded pready wait, response handshake out.
module apb_initiator
  import timer_apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout
);

  apb_state_e state;
  logic       expire;

  apb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != ST_ACCESS),
    .en     (state == ST_ACCESS && !pready),
    .expire (expire)
  );

  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          pwrite <= cmd_write;
          paddr  <= cmd_addr;
          // reads leave pwdata untouched so the bus does not toggle needlessly
          if (cmd_write) begin
            pwdata <= cmd_wdata;
            pstrb  <= cmd_strb;
          end else begin
            pstrb  <= '0;
          end
          psel   <= 1'b1;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: if (pready) begin
          rsp_rdata   <= pwrite ? '0 : prdata;
          rsp_err     <= pslverr;
          rsp_timeout <= 1'b0;
          rsp_valid   <= 1'b1;
          psel        <= 1'b0;
          penable     <= 1'b0;
          state       <= ST_RESP;
        end else if (expire) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
          rsp_valid   <= 1'b1;
          psel        <= 1'b0;
          penable     <= 1'b0;
          state       <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: behavioural timer-register slave plus a response
// scoreboard; scenario tasks check bus timing directly.
module tb_apb_initiator;
  import timer_apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  apb_initiator #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  // Timer register slave: TCMP0/1 reset to all ones, errors above 0x01C
  logic [31:0] regs [8];
  int          wait_states = 0;
  bit          hang = 1'b0;
  int          acc_cnt = 0;

  initial for (int i = 0; i < 8; i++) regs[i] = (i == 3 || i == 4) ? 32'hFFFF_FFFF : 32'h0;

  assign pready  = psel && penable && !hang && (acc_cnt >= wait_states);
  assign pslverr = pready && (paddr >= 12'h020);
  assign prdata  = (paddr < 12'h020) ? regs[paddr[4:2]] : 32'h0;

  always @(posedge clk) begin
    acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
    if (psel && penable && pready && pwrite && paddr < 12'h020)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) regs[paddr[4:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
  end

  always @(negedge clk) begin : mon
    rsp_t e;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_rsp: got response rdata=%h, required none", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rdata) begin
          n_fails++; $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e.rdata);
        end
        n_checks++;
        if (rsp_err !== e.err) begin
          n_fails++; $display("FAIL rsp_err: got %b, required %b", rsp_err, e.err);
        end
        n_checks++;
        if (rsp_timeout !== e.tmo) begin
          n_fails++; $display("FAIL rsp_timeout: got %b, required %b", rsp_timeout, e.tmo);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one command for a single accepted cycle; returns in the SETUP cycle.
  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee,
                       input logic et, input bit push = 1'b1);
    rsp_t x;
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin tick(); t++; end
    if (cmd_ready !== 1'b1) begin
      n_checks++; n_fails++;
      $display("FAIL issue_wait: cmd_ready=%b, required 1", cmd_ready);
    end
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
    x.rdata = er; x.err = ee; x.tmo = et;
    if (push) exp_q.push_back(x);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (rsp_valid !== 1'b1 && t < 50) begin tick(); t++; end
    if (rsp_valid !== 1'b1) begin
      n_checks++; n_fails++;
      $display("FAIL wait_rsp: rsp_valid=%b, required 1", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
    end
    n_checks++;
    if ({paddr, pwdata, pstrb, rsp_rdata} !== 80'h0) begin
      n_fails++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h pstrb=%h rdata=%h, required 0",
               paddr, pwdata, pstrb, rsp_rdata);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_latency();
    issue(1'b1, TCR_OFF, 32'h0000_0103, 4'hF, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({psel, penable, cmd_ready} !== 3'b100) begin
      n_fails++; $display("FAIL setup_cycle1: psel/penable/cmd_ready=%b, required 100",
                          {psel, penable, cmd_ready});
    end
    n_checks++;
    if (pwrite !== 1'b1 || paddr !== TCR_OFF || pwdata !== 32'h103 || pstrb !== 4'hF) begin
      n_fails++; $display("FAIL setup_bus: w=%b a=%h d=%h s=%h, required 1 000 00000103 f",
                          pwrite, paddr, pwdata, pstrb);
    end
    tick();
    n_checks++;
    if ({psel, penable} !== 2'b11) begin
      n_fails++; $display("FAIL access_cycle2: psel/penable=%b, required 11", {psel, penable});
    end
    tick();
    n_checks++;
    if ({rsp_valid, psel, penable} !== 3'b100) begin
      n_fails++; $display("FAIL resp_cycle3: rsp_valid/psel/penable=%b, required 100",
                          {rsp_valid, psel, penable});
    end
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fails++; $display("FAIL idle_cycle4: cmd_ready/rsp_valid=%b, required 10",
                          {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_read_back();
    issue(1'b0, TCR_OFF, 32'hA5A5_A5A5, 4'hF, 32'h0000_0103, 1'b0, 1'b0);
    n_checks++;
    if (pwrite !== 1'b0 || pstrb !== 4'h0 || pwdata !== 32'h103) begin
      n_fails++; $display("FAIL read_setup: w=%b s=%h d=%h, required 0 0 00000103",
                          pwrite, pstrb, pwdata);
    end
    wait_rsp();
    tick();
  endtask

  task automatic test_read_wait();
    int n = 0;
    bit stable = 1'b1;
    wait_states = 2;
    issue(1'b0, TCMP0_OFF, 32'h0, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    while (penable === 1'b1 && n < 40) begin
      n++;
      if (paddr !== TCMP0_OFF || pstrb !== 4'h0 || psel !== 1'b1) stable = 1'b0;
      tick();
    end
    n_checks++;
    if (n != 3) begin
      n_fails++; $display("FAIL wait_access_len: got %0d, required 3", n);
    end
    n_checks++;
    if (!stable) begin
      n_fails++; $display("FAIL wait_bus_stable: got unstable, required stable");
    end
    tick();
    wait_states = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    hang = 1'b1;
    issue(1'b0, TDR0_OFF, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    tick();
    while (penable === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if (n != 8) begin
      n_fails++; $display("FAIL timeout_len: got %0d, required 8", n);
    end
    tick();
    hang = 1'b0;
    wait_states = 7;
    n = 0;
    issue(1'b0, TCMP1_OFF, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    while (penable === 1'b1 && n < 40) begin n++; tick(); end
    n_checks++;
    if (n != 8) begin
      n_fails++; $display("FAIL last_cycle_len: got %0d, required 8", n);
    end
    tick();
    wait_states = 0;
  endtask

  task automatic test_slverr();
    issue(1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 1'b0);
    wait_rsp();
    tick();
  endtask

  task automatic test_backpressure();
    bit ok = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, TCR_OFF, 32'h0, 4'h0, 32'h0000_0103, 1'b0, 1'b0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h103 || rsp_err !== 1'b0 ||
          rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 || psel !== 1'b0) ok = 1'b0;
      if (i == 2) begin
        cmd_write = 1'b1; cmd_addr = TIER_OFF; cmd_wdata = 32'h1234_5678;
        cmd_strb = 4'hF; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_fails++; $display("FAIL backpressure_hold: got fields/ready changing, required held");
    end
    rsp_ready = 1'b1;
    tick(2);
    n_checks++;
    if (psel !== 1'b0) begin
      n_fails++; $display("FAIL ignored_cmd: psel=%b, required 0", psel);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    int t = 0;
    d1 = $urandom;
    d2 = $urandom;
    issue(1'b1, TDR0_OFF, d1, 4'b0101, 32'h0, 1'b0, 1'b0);
    issue(1'b0, TIER_OFF, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, TDR0_OFF, 32'h0, 4'h0, d1 & 32'h00FF_00FF, 1'b0, 1'b0);
    issue(1'b1, TIER_OFF, d2, 4'hF, 32'h0, 1'b0, 1'b0);
    issue(1'b0, TIER_OFF, 32'h0, 4'h0, d2, 1'b0, 1'b0);
    issue(1'b1, THCSR_OFF, d1, 4'b1000, 32'h0, 1'b0, 1'b0);
    issue(1'b0, THCSR_OFF, 32'h0, 4'h0, d1 & 32'hFF00_0000, 1'b0, 1'b0);
    while (exp_q.size() != 0 && t < 50) begin tick(); t++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++; $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    issue(1'b0, TCMP0_OFF, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (penable !== 1'b1) begin
      n_fails++; $display("FAIL pre_reset_access: penable=%b, required 1", penable);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, rsp_valid} !== 3'b000) begin
      n_fails++; $display("FAIL async_reset: psel/penable/rsp_valid=%b, required 000",
                          {psel, penable, rsp_valid});
    end
    tick(2);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fails++; $display("FAIL post_reset_ready: got %b, required 1", cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0 || psel !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (!quiet) begin
      n_fails++; $display("FAIL stale_rsp: got activity after reset, required none");
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_write_latency();
    test_read_back();
    test_read_wait();
    test_timeout();
    test_slverr();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
